// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU first, with a
// bounded wait so the debug/DMA port cannot starve.
module data_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int DBG_MAX_WAIT = 4,
  parameter int WAIT_W       = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_XFER = 2'd1,
    DBG_XFER = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(DBG_MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (dbg_req && (!cpu_req || wait_q >= WAIT_LIM)) begin
          state_d = DBG_XFER;
          wait_d  = '0;
        end else if (cpu_req) begin
          state_d = CPU_XFER;
          // each contested loss brings debug closer to a forced win
          if (dbg_req && wait_q != WAIT_SAT) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read     = 1'b0;
    unique case (1'b1)
      (state_q == CPU_XFER): begin
        cpu_gnt      = 1'b1;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_write_en = cpu_we;
        mem_read     = ~cpu_we;
      end
      (state_q == DBG_XFER): begin
        dbg_gnt      = 1'b1;
        mem_addr     = dbg_addr;
        mem_wdata    = dbg_wdata;
        mem_write_en = dbg_we;
        mem_read     = ~dbg_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    dbg_rvalid_d = dbg_gnt & ~dbg_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_read_data : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_read_data : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
